// File: rtl/operand_feeder.sv
// Host-to-accelerator operand buffer: circular store feeding fixed-length bursts over data_rdy/read_en.
// Define OPERAND_FEEDER_ERR_EN to build the sticky protocol-error flag on err_o.
module operand_feeder #(
    parameter int WIDTH_DATA = 16,
    parameter int DEPTH_LOG2 = 7,
    parameter int BURST_LEN  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid_i,
    input  logic [WIDTH_DATA-1:0] wr_data_i,
    output logic                  wr_ready_o,
    output logic                  data_rdy_o,
    input  logic                  read_en_i,
    output logic [WIDTH_DATA-1:0] data_o,
    output logic                  data_vld_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  err_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] BURST_C = CW'(BURST_LEN);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READY  = 2'd1,
        STREAM = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           count_q, count_d;
    logic [CW-1:0]           burst_cnt_q, burst_cnt_d;
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, rd_ptr_q;
    logic [WIDTH_DATA-1:0]   data_q;
    logic                    vld_q;
    logic [WIDTH_DATA-1:0]   mem_q [DEPTH];

    logic wr_acc, rd_acc;

    assign wr_ready_o = (count_q != DEPTH_C);
    assign data_rdy_o = (state_q == READY) || (state_q == STREAM);
    assign wr_acc     = wr_valid_i && wr_ready_o;
    assign rd_acc     = read_en_i && data_rdy_o && (count_q != '0);

    always_comb begin
        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            IDLE: begin
                if (count_d >= BURST_C) state_d = READY;
            end
            READY: begin
                if (rd_acc) begin
                    if (BURST_LEN == 1) begin
                        state_d = (count_d >= BURST_C) ? READY : IDLE;
                    end else begin
                        state_d     = STREAM;
                        burst_cnt_d = CW'(1);
                    end
                end
            end
            STREAM: begin
                if (rd_acc) begin
                    if (burst_cnt_q == BURST_C - 1'b1) begin
                        burst_cnt_d = '0;
                        state_d     = (count_d >= BURST_C) ? READY : IDLE;
                    end else begin
                        burst_cnt_d = burst_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                burst_cnt_d = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            burst_cnt_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            data_q      <= '0;
            vld_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            burst_cnt_q <= burst_cnt_d;
            vld_q       <= rd_acc;
            if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_acc) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                data_q   <= mem_q[rd_ptr_q];
            end
        end
    end

    // NOTE: storage has no reset; contents are don't-care until written, and pointers guard every read.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign data_o     = data_q;
    assign data_vld_o = vld_q;
    assign count_o    = count_q;

`ifdef OPERAND_FEEDER_ERR_EN
    logic err_q;

    // Sticky: an illegal read or a write presented while full latches until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if ((read_en_i && !data_rdy_o) || (wr_valid_i && !wr_ready_o)) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_operand_feeder.sv
// Directed bench for operand_feeder: expected read words queue in a scoreboard, a monitor pops on data_vld_o.
module tb_operand_feeder;

    localparam int W  = 16;
    localparam int DL = 7;
`ifdef OPERAND_FEEDER_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_valid_i = 1'b0;
    logic [W-1:0]  wr_data_i = '0;
    logic          wr_ready_o;
    logic          data_rdy_o;
    logic          read_en_i = 1'b0;
    logic [W-1:0]  data_o;
    logic          data_vld_o;
    logic [DL:0]   count_o;
    logic          err_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] sb [$];

    operand_feeder #(.WIDTH_DATA(W), .DEPTH_LOG2(DL), .BURST_LEN(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid_i (wr_valid_i),
        .wr_data_i  (wr_data_i),
        .wr_ready_o (wr_ready_o),
        .data_rdy_o (data_rdy_o),
        .read_en_i  (read_en_i),
        .data_o     (data_o),
        .data_vld_o (data_vld_o),
        .count_o    (count_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; applies inputs for one rising edge and returns at the next negedge.
    task automatic drive(input logic wv, input logic [W-1:0] wd, input logic re);
        wr_valid_i = wv;
        wr_data_i  = wd;
        read_en_i  = re;
        @(negedge clk);
        wr_valid_i = 1'b0;
        read_en_i  = 1'b0;
    endtask

    task automatic write_words(input int base, input int n);
        for (int i = 0; i < n; i++) drive(1'b1, W'(base + i), 1'b0);
    endtask

    // Reads n words expected to be base..base+n-1; data_rdy_o must stay high until the last read.
    task automatic read_words(input int base, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            sb.push_back(W'(base + i));
            drive(1'b0, '0, 1'b1);
            if (i < n - 1 && data_rdy_o !== 1'b1)
                check({tag, "_rdy_held"}, 32'(data_rdy_o), 32'd1);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && data_vld_o) begin
            if (sb.size() == 0) begin
                check("unexpected_vld", 32'(data_o), 32'hFFFF_FFFF);
            end else begin
                check("data_o", 32'(data_o), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        #1;
        check("rst_count", 32'(count_o), 32'd0);
        check("rst_wr_ready", 32'(wr_ready_o), 32'd1);
        check("rst_data_rdy", 32'(data_rdy_o), 32'd0);
        check("rst_data_vld", 32'(data_vld_o), 32'd0);
        check("rst_data", 32'(data_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Illegal read while idle
        drive(1'b0, '0, 1'b1);
        check("illegal_err", 32'(err_o), 32'(ERR_EXP));
        check("illegal_count", 32'(count_o), 32'd0);
        check("illegal_vld", 32'(data_vld_o), 32'd0);

        // Fill to one below a burst, then the threshold write
        write_words(0, 63);
        check("w63_rdy", 32'(data_rdy_o), 32'd0);
        check("w63_count", 32'(count_o), 32'd63);
        drive(1'b1, W'(63), 1'b0);
        check("w64_rdy", 32'(data_rdy_o), 32'd1);
        check("w64_count", 32'(count_o), 32'd64);

        read_words(0, 64, "b1");
        check("b1_rdy_fall", 32'(data_rdy_o), 32'd0);
        check("b1_count", 32'(count_o), 32'd0);
        drive(1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b0);
        check("b1_vld_low", 32'(data_vld_o), 32'd0);

        // Full buffer with wrapped pointers, dropped write, two back-to-back bursts
        write_words(0, 128);
        check("full_wr_ready", 32'(wr_ready_o), 32'd0);
        check("full_count", 32'(count_o), 32'd128);
        drive(1'b1, 16'hDEAD, 1'b0);
        check("drop_count", 32'(count_o), 32'd128);
        check("drop_err", 32'(err_o), 32'(ERR_EXP));
        read_words(0, 128, "b2");
        check("b2_rdy_fall", 32'(data_rdy_o), 32'd0);
        check("b2_count", 32'(count_o), 32'd0);
        drive(1'b1, 16'hABCD, 1'b0);
        write_words(16'h1001, 63);
        check("abcd_rdy", 32'(data_rdy_o), 32'd1);
        sb.push_back(16'hABCD);
        drive(1'b0, '0, 1'b1);
        read_words(16'h1001, 63, "b3");
        check("b3_count", 32'(count_o), 32'd0);

        // Concurrent write and read through a whole burst
        write_words(200, 64);
        for (int i = 0; i < 64; i++) begin
            sb.push_back(W'(200 + i));
            drive(1'b1, W'(300 + i), 1'b1);
            if (count_o !== 64 || data_rdy_o !== 1'b1) begin
                check("conc_count", 32'(count_o), 32'd64);
                check("conc_rdy", 32'(data_rdy_o), 32'd1);
            end
        end
        check("conc_end_count", 32'(count_o), 32'd64);
        check("conc_end_rdy", 32'(data_rdy_o), 32'd1);
        read_words(300, 64, "b4");
        check("b4_count", 32'(count_o), 32'd0);
        drive(1'b0, '0, 1'b0);

        // Reset in the middle of a burst
        write_words(400, 64);
        read_words(400, 10, "b5");
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_count", 32'(count_o), 32'd0);
        check("mid_rst_rdy", 32'(data_rdy_o), 32'd0);
        check("mid_rst_wr_ready", 32'(wr_ready_o), 32'd1);
        check("mid_rst_vld", 32'(data_vld_o), 32'd0);
        check("mid_rst_data", 32'(data_o), 32'd0);
        check("mid_rst_err", 32'(err_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        write_words(500, 64);
        check("post_rst_rdy", 32'(data_rdy_o), 32'd1);
        read_words(500, 64, "b6");
        check("b6_count", 32'(count_o), 32'd0);
        drive(1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
